// File: rtl/switch_egress_port.sv
// Egress buffer for one switch output port: stores strobed words in a FIFO,
// drops on overflow with a saturating drop counter, and exposes fill status.
module switch_egress_port #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int AF_THRESH  = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         almost_full,
  output logic [CNT_WIDTH-1:0]         drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;

  logic full, pop, push, drop;

  assign full = (fill_q == FW'(DEPTH));
  assign pop  = (fill_q != '0) && out_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    drop_cnt_d = drop_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage carries no reset; contents are only observable through valid entries.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!reset && push && (wr_ptr_q == PW'(gi))) mem_q[gi] <= in_data;
      end
    end
  endgenerate

  assign out_valid   = (fill_q != '0);
  assign out_data    = mem_q[rd_ptr_q];
  assign fill_level  = fill_q;
  assign almost_full = (fill_q >= FW'(AF_THRESH));
  assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_switch_egress_port.sv
// Randomised and directed checks of switch_egress_port against a queue model;
// a second instance with a 2-bit drop counter exercises saturation.
module tb_switch_egress_port;

  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int AF    = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          out_valid,  out_valid2;
  logic [DW-1:0] out_data,   out_data2;
  logic [3:0]    fill_level, fill_level2;
  logic          almost_full, almost_full2;
  logic [15:0]   drop_count;
  logic [1:0]    drop_count2;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model_q[$];
  int            model_drops = 0;
  bit            started = 0;

  always #5 clk = ~clk;

  switch_egress_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fill_level(fill_level), .almost_full(almost_full), .drop_count(drop_count)
  );

  switch_egress_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .fill_level(fill_level2), .almost_full(almost_full2), .drop_count(drop_count2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a plain queue updated once per rising edge.
  always @(posedge clk) begin
    bit do_pop, do_push;
    started = 1;
    if (reset) begin
      model_q.delete();
      model_drops = 0;
    end else begin
      do_pop  = (model_q.size() != 0) && out_ready;
      do_push = in_valid && ((model_q.size() < DEPTH) || do_pop);
      if (do_pop) begin
        $display("pop  data=%h", model_q[0]);
        void'(model_q.pop_front());
      end
      if (do_push) model_q.push_back(in_data);
      else if (in_valid) model_drops++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
      check("fill_level", 64'(fill_level), 64'(model_q.size()));
      check("almost_full", 64'(almost_full), 64'(model_q.size() >= AF));
      check("drop_count", 64'(drop_count), 64'(model_drops > 65535 ? 65535 : model_drops));
      check("drop_count_sat", 64'(drop_count2), 64'(model_drops > 3 ? 3 : model_drops));
      check("fill_level_sat", 64'(fill_level2), 64'(model_q.size()));
      if (model_q.size() != 0) begin
        check("out_data", out_data, model_q[0]);
        check("out_data_sat", out_data2, model_q[0]);
      end
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic r, input logic rst);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] abc [3];
    in_valid = 0; in_data = '0; out_ready = 0; reset = 1;
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);

    // single word, one-cycle latency
    step(1, 64'hDEADBEEFCAFEBABE, 1, 0);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data", out_data, 64'hDEADBEEFCAFEBABE);
    step(0, 0, 1, 0);
    check("lat_empty", 64'(out_valid), 64'd0);

    // three words held, then drained back to back
    abc[0] = 64'hAAAAAAAAAAAAAAAA; abc[1] = 64'hBBBBBBBBBBBBBBBB; abc[2] = 64'hCCCCCCCCCCCCCCCC;
    for (int i = 0; i < 3; i++) step(1, abc[i], 0, 0);
    check("abc_fill", 64'(fill_level), 64'd3);
    check("abc_head", out_data, abc[0]);
    for (int i = 0; i < 3; i++) begin
      check("abc_order", out_data, abc[i]);
      step(0, 0, 1, 0);
    end
    check("abc_empty", 64'(out_valid), 64'd0);

    // overflow by two
    for (int i = 0; i < 10; i++) begin
      step(1, 64'h1000 + 64'(i), 0, 0);
      check("af_ramp", 64'(almost_full), 64'((i + 1 >= AF) && 1));
    end
    check("ovf_fill", 64'(fill_level), 64'd8);
    check("ovf_drop", 64'(drop_count), 64'd2);
    for (int i = 0; i < 8; i++) begin
      check("ovf_order", out_data, 64'h1000 + 64'(i));
      step(0, 0, 1, 0);
    end

    // full FIFO, push with pop on the same edge
    for (int i = 0; i < 8; i++) step(1, 64'h2000 + 64'(i), 0, 0);
    step(1, 64'h2FFF, 1, 0);
    check("fullpp_fill", 64'(fill_level), 64'd8);
    check("fullpp_drop", 64'(drop_count), 64'd2);
    for (int i = 1; i < 8; i++) begin
      check("fullpp_order", out_data, 64'h2000 + 64'(i));
      step(0, 0, 1, 0);
    end
    check("fullpp_new", out_data, 64'h2FFF);
    step(0, 0, 1, 0);

    // reset flushes stored words and the drop count
    for (int i = 0; i < 5; i++) step(1, 64'h3000 + 64'(i), 0, 0);
    step(1, 64'h3FFF, 1, 1);
    check("flush_fill", 64'(fill_level), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_drop", 64'(drop_count), 64'd0);
    step(1, 64'h900DDA7A00000000, 0, 0);
    check("flush_fill1", 64'(fill_level), 64'd1);
    check("flush_data", out_data, 64'h900DDA7A00000000);
    step(0, 0, 1, 0);
    check("flush_empty", 64'(out_valid), 64'd0);

    // drop counter saturation on the 2-bit instance
    for (int i = 0; i < 8; i++) step(1, 64'h4000 + 64'(i), 0, 0);
    for (int i = 0; i < 5; i++) step(1, 64'h4100 + 64'(i), 0, 0);
    check("sat_drop2", 64'(drop_count2), 64'd3);
    check("sat_drop16", 64'(drop_count), 64'd5);
    step(1, 64'h4200, 0, 0);
    check("sat_hold", 64'(drop_count2), 64'd3);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    // random traffic with phases of light and heavy backpressure
    for (int i = 0; i < 3000; i++) begin
      int ready_pct;
      ready_pct = ((i / 200) % 3 == 0) ? 20 : (((i / 200) % 3 == 1) ? 90 : 55);
      step($urandom_range(99) < 60,
           {$urandom, $urandom},
           $urandom_range(99) < ready_pct,
           $urandom_range(299) == 0);
    end
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
